// File: rtl/regbank_sequencer.sv
// rtl/regbank_sequencer.sv - command-driven read/write sequencer for the 8x8 register bank
module regbank_sequencer (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_rd,
    input  logic [2:0] cmd_rs,
    input  logic [7:0] cmd_imm,
    input  logic [7:0] bus_in,
    output logic [2:0] bank_en_in,
    output logic [7:0] bank_wdata,
    output logic [2:0] bank_out_index,
    output logic       bank_out_enable,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       done
);

    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_LDI  = 2'b01;
    localparam logic [1:0] OP_SWAP = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        WR_A = 3'd3,
        WR_B = 3'd4,
        FIN  = 3'd5
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] op_q;
    logic [2:0] rd_q;
    logic [2:0] rs_q;
    logic [7:0] imm_q;
    logic [7:0] t0;
    logic [7:0] t1;

    // State register; RESET aborts any command in flight immediately
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the whole command on acceptance so inputs are free afterwards
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            op_q  <= OP_MOV;
            rd_q  <= 3'd0;
            rs_q  <= 3'd0;
            imm_q <= 8'h00;
        end else if (state == IDLE && cmd_valid) begin
            op_q  <= cmd_op;
            rd_q  <= cmd_rd;
            rs_q  <= cmd_rs;
            imm_q <= cmd_imm;
        end
    end

    // Sample the read bus in the read states; READ results persist until the next READ
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            t0       <= 8'h00;
            t1       <= 8'h00;
            rsp_data <= 8'h00;
        end else begin
            if (state == RD_A) begin
                t0 <= bus_in;
                if (op_q == OP_READ) begin
                    rsp_data <= bus_in;
                end
            end
            if (state == RD_B) begin
                t1 <= bus_in;
            end
        end
    end

    // Next-state sequencing per command type
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt = (cmd_op == OP_LDI) ? WR_A : RD_A;
                end
            end
            RD_A: begin
                case (op_q)
                    OP_MOV:  state_nxt = WR_A;
                    OP_SWAP: state_nxt = RD_B;
                    default: state_nxt = FIN;
                endcase
            end
            RD_B:    state_nxt = WR_A;
            WR_A:    state_nxt = (op_q == OP_SWAP) ? WR_B : FIN;
            WR_B:    state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bank and handshake outputs decoded from registered state only; read and write never overlap
    always_comb begin
        cmd_ready       = 1'b0;
        bank_en_in      = 3'd0;
        bank_wdata      = 8'h00;
        bank_out_index  = 3'd0;
        bank_out_enable = 1'b0;
        rsp_valid       = 1'b0;
        done            = 1'b0;
        case (state)
            IDLE: cmd_ready = 1'b1;
            RD_A: begin
                bank_out_index  = rs_q;
                bank_out_enable = 1'b1;
            end
            RD_B: begin
                bank_out_index  = rd_q;
                bank_out_enable = 1'b1;
            end
            WR_A: begin
                bank_en_in = rd_q;
                bank_wdata = (op_q == OP_LDI) ? imm_q : t0;
            end
            WR_B: begin
                bank_en_in = rs_q;
                bank_wdata = t1;
            end
            FIN: begin
                done      = 1'b1;
                rsp_valid = (op_q == OP_READ);
            end
            default: cmd_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_regbank_sequencer.sv
// tb/tb_regbank_sequencer.sv - randomized self-checking bench for regbank_sequencer
module tb_regbank_sequencer;

    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_LDI  = 2'b01;
    localparam logic [1:0] OP_SWAP = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [2:0] cmd_rd = 3'd0;
    logic [2:0] cmd_rs = 3'd0;
    logic [7:0] cmd_imm = 8'h00;
    logic [7:0] bus_in;
    logic [2:0] bank_en_in;
    logic [7:0] bank_wdata;
    logic [2:0] bank_out_index;
    logic       bank_out_enable;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       done;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] bank [8];
    logic [7:0] noise = 8'h00;
    logic [7:0] ref_regs [8];
    logic [7:0] ref_rsp = 8'h00;

    regbank_sequencer dut (
        .CLK(CLK),
        .RESET(RESET),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_rd(cmd_rd),
        .cmd_rs(cmd_rs),
        .cmd_imm(cmd_imm),
        .bus_in(bus_in),
        .bank_en_in(bank_en_in),
        .bank_wdata(bank_wdata),
        .bank_out_index(bank_out_index),
        .bank_out_enable(bank_out_enable),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .done(done)
    );

    always #5 CLK = ~CLK;

    // Register bank: register 0 is never writable, bus carries garbage when not enabled
    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++) bank[i] <= 8'h00;
        end else if (bank_en_in != 3'd0) begin
            bank[bank_en_in] <= bank_wdata;
        end
    end

    always @(negedge CLK) noise <= 8'($urandom);

    assign bus_in = bank_out_enable ? bank[bank_out_index] : noise;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
        end
    endtask

    task automatic chk_bank(input string tag);
        for (int i = 0; i < 8; i++) chk(tag, 32'(bank[i]), 32'(ref_regs[i]));
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                           input logic [7:0] imm);
        logic [14:0] exp_wr[$];
        logic [14:0] got_wr[$];
        logic [6:0]  exp_rd[$];
        logic [6:0]  got_rd[$];
        int exp_lat;
        int done_cyc;
        int ndone;
        int ovl;
        int busy_bad;
        logic rv_at;
        logic [7:0] rdat_at;
        logic [7:0] src_v;
        logic [7:0] dst_v;
        src_v = ref_regs[rs];
        dst_v = ref_regs[rd];
        exp_lat = 0;
        case (op)
            OP_LDI: begin
                exp_lat = 2;
                if (rd != 3'd0) begin
                    exp_wr.push_back({4'd1, rd, imm});
                    ref_regs[rd] = imm;
                end
            end
            OP_MOV: begin
                exp_lat = 3;
                exp_rd.push_back({4'd1, rs});
                if (rd != 3'd0) begin
                    exp_wr.push_back({4'd2, rd, src_v});
                    ref_regs[rd] = src_v;
                end
            end
            OP_SWAP: begin
                exp_lat = 5;
                exp_rd.push_back({4'd1, rs});
                exp_rd.push_back({4'd2, rd});
                if (rd != 3'd0) exp_wr.push_back({4'd3, rd, src_v});
                if (rs != 3'd0) exp_wr.push_back({4'd4, rs, dst_v});
                if (rd != 3'd0) ref_regs[rd] = src_v;
                if (rs != 3'd0) ref_regs[rs] = dst_v;
            end
            default: begin
                exp_lat = 2;
                exp_rd.push_back({4'd1, rs});
                ref_rsp = src_v;
            end
        endcase

        done_cyc = 0; ndone = 0; ovl = 0; busy_bad = 0; rv_at = 1'b0; rdat_at = 8'h00;
        @(negedge CLK);
        chk("ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_imm = imm;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge CLK);
            if (cyc == 1) begin
                cmd_valid = 1'b0;
                cmd_op = 2'($urandom); cmd_rd = 3'($urandom);
                cmd_rs = 3'($urandom); cmd_imm = 8'($urandom);
            end
            if (done_cyc != 0) begin
                chk("ready_after_done", 32'(cmd_ready), 32'd1);
                if (done) ndone++;
                break;
            end
            if (cmd_ready) busy_bad++;
            if (bank_en_in != 3'd0) got_wr.push_back({4'(cyc), bank_en_in, bank_wdata});
            if (bank_out_enable) got_rd.push_back({4'(cyc), bank_out_index});
            if (bank_out_enable && bank_en_in != 3'd0) ovl++;
            if (done) begin
                done_cyc = cyc; ndone++; rv_at = rsp_valid; rdat_at = rsp_data;
            end
        end
        chk("latency", 32'(done_cyc), 32'(exp_lat));
        chk("done_pulses", 32'(ndone), 32'd1);
        chk("bus_write_overlap", 32'(ovl), 32'd0);
        chk("ready_while_busy", 32'(busy_bad), 32'd0);
        chk("write_count", 32'(got_wr.size()), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            chk("write_event", 32'(got_wr[i]), 32'(exp_wr[i]));
        chk("read_count", 32'(got_rd.size()), 32'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++)
            chk("read_event", 32'(got_rd[i]), 32'(exp_rd[i]));
        chk("rsp_valid", 32'(rv_at), 32'(op == OP_READ));
        chk("rsp_data", 32'(rdat_at), 32'(ref_rsp));
        chk_bank("bank_reg");
    endtask

    initial begin
        int dq[$];
        int rdy_first;
        int bad;
        for (int i = 0; i < 8; i++) ref_regs[i] = 8'h00;

        #2;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_bank_en_in", 32'(bank_en_in), 32'd0);
        chk("rst_bank_wdata", 32'(bank_wdata), 32'd0);
        chk("rst_out_index", 32'(bank_out_index), 32'd0);
        chk("rst_out_enable", 32'(bank_out_enable), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;

        run_cmd(OP_LDI, 3'd3, 3'd0, 8'h5A);
        run_cmd(OP_MOV, 3'd5, 3'd3, 8'h00);
        run_cmd(OP_LDI, 3'd2, 3'd0, 8'h11);
        run_cmd(OP_LDI, 3'd6, 3'd0, 8'hEE);
        run_cmd(OP_SWAP, 3'd2, 3'd6, 8'h00);
        run_cmd(OP_LDI, 3'd0, 3'd0, 8'hFF);
        run_cmd(OP_READ, 3'd0, 3'd0, 8'h00);
        run_cmd(OP_SWAP, 3'd5, 3'd5, 8'h00);
        run_cmd(OP_SWAP, 3'd0, 3'd2, 8'h00);

        // MOV with a second LDI held on cmd_valid throughout
        @(negedge CLK);
        cmd_valid = 1'b1; cmd_op = OP_MOV; cmd_rd = 3'd4; cmd_rs = 3'd6; cmd_imm = 8'h00;
        rdy_first = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge CLK);
            if (cyc == 1) begin
                cmd_op = OP_LDI; cmd_rd = 3'd7; cmd_imm = 8'hC3;
            end
            if (done) dq.push_back(cyc);
            if (rdy_first != 0 && cyc == rdy_first + 1) cmd_valid = 1'b0;
            if (cmd_ready && rdy_first == 0) rdy_first = cyc;
        end
        ref_regs[4] = ref_regs[6];
        ref_regs[7] = 8'hC3;
        chk("b2b_first_ready", 32'(rdy_first), 32'd4);
        chk("b2b_done_count", 32'(dq.size()), 32'd2);
        if (dq.size() >= 1) chk("b2b_done_mov", 32'(dq[0]), 32'd3);
        if (dq.size() >= 2) chk("b2b_done_ldi", 32'(dq[1]), 32'd6);
        chk_bank("b2b_bank");

        run_cmd(OP_READ, 3'd0, 3'd5, 8'h00);

        for (int n = 0; n < 60; n++) begin
            run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 8'($urandom));
        end

        // Reset during RD_B of a SWAP
        run_cmd(OP_LDI, 3'd1, 3'd0, 8'h21);
        run_cmd(OP_LDI, 3'd6, 3'd0, 8'h66);
        run_cmd(OP_READ, 3'd0, 3'd6, 8'h00);
        @(negedge CLK);
        cmd_valid = 1'b1; cmd_op = OP_SWAP; cmd_rd = 3'd1; cmd_rs = 3'd6;
        @(negedge CLK);
        cmd_valid = 1'b0;
        @(negedge CLK);
        chk("rdb_index", 32'(bank_out_index), 32'd1);
        #1 RESET = 1'b1;
        #1;
        chk("ar_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("ar_bank_en_in", 32'(bank_en_in), 32'd0);
        chk("ar_bank_wdata", 32'(bank_wdata), 32'd0);
        chk("ar_out_index", 32'(bank_out_index), 32'd0);
        chk("ar_out_enable", 32'(bank_out_enable), 32'd0);
        chk("ar_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("ar_rsp_data", 32'(rsp_data), 32'd0);
        chk("ar_done", 32'(done), 32'd0);
        for (int i = 0; i < 8; i++) ref_regs[i] = 8'h00;
        ref_rsp = 8'h00;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (bank_en_in != 3'd0 || done || bank_out_enable) bad++;
        end
        RESET = 1'b0;
        chk("ar_quiet", 32'(bad), 32'd0);
        @(negedge CLK);
        chk("ar_ready_after", 32'(cmd_ready), 32'd1);
        chk("ar_no_done", 32'(done), 32'd0);
        chk_bank("ar_bank");

        for (int n = 0; n < 10; n++) begin
            run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regbank_sequencer.md
# regbank_sequencer

Command-driven master for the 8-entry, 8-bit register bank: it owns the bank's write port and its tri-stated read bus. It accepts one register-transfer command at a time through a valid/ready handshake and sequences the bank's read-select, bus-enable, write-select and write-data lines. Supported commands are load-immediate, move, swap and read-out. It sits between instruction decode and the register bank.

## Interface
Parameters:
- None. Widths are fixed: 8-bit data, 3-bit register index.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  a command is presented.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready at a rising edge.
- cmd_op  in  2  command code: 00 MOV (rd←rs), 01 LDI (rd←imm), 10 SWAP (rd↔rs), 11 READ (rs→rsp_data).
- cmd_rd  in  3  destination register index.
- cmd_rs  in  3  source register index.
- cmd_imm  in  8  immediate value for LDI.
- bus_in  in  8  bank read bus; valid only while bank_out_enable=1.
- bank_en_in  out  3  bank write-select; 0 means no write, because register 0 is hardwired zero.
- bank_wdata  out  8  bank write data.
- bank_out_index  out  3  bank read-select.
- bank_out_enable  out  1  bank read-bus tristate enable.
- rsp_valid  out  1  one-cycle pulse; rsp_data is valid (READ only).
- rsp_data  out  8  value read by READ; holds until the next READ completes.
- done  out  1  one-cycle pulse at completion of any command.

## Operation
- All command fields are captured into internal registers on acceptance. Input fields are don't-care afterwards.
- Two 8-bit temporaries, t0 and t1, hold bus samples.
- States: IDLE, RD_A, RD_B, WR_A, WR_B, FIN.
- Transitions from IDLE on accept:
  - LDI → WR_A.
  - MOV, READ, SWAP → RD_A.
- RD_A: bank_out_index=rs, bank_out_enable=1; t0←bus_in at the edge.
  - MOV → WR_A.
  - READ → FIN.
  - SWAP → RD_B.
- RD_B (SWAP only): bank_out_index=rd, bank_out_enable=1; t1←bus_in → WR_A.
- WR_A: bank_en_in=rd; bank_wdata = imm for LDI, else t0.
  - SWAP → WR_B.
  - Others → FIN.
- WR_B (SWAP only): bank_en_in=rs, bank_wdata=t1 → FIN.
- FIN: done=1. For READ, rsp_valid=1 and rsp_data=t0 (registered at the RD_A edge). Next state is IDLE.
- Outside read states, bank_out_enable=0. Outside write states, bank_en_in=0. The bus is therefore never driven while a write is in progress.
- rd=0 or rs=0 is legal:
  - Writes to register 0 drive bank_en_in=0 and are dropped.
  - Reads of register 0 return 0x00.
  - Cycle count is unchanged.
- SWAP with rd==rs leaves the register unchanged.
- Commands presented while cmd_ready=0 are ignored. There is no queueing.

## Timing
- Reset values (asynchronous, effective immediately):
  - state=IDLE; cmd_ready=1.
  - bank_en_in=0, bank_wdata=0x00, bank_out_index=0, bank_out_enable=0.
  - rsp_valid=0, rsp_data=0x00, done=0; t0=t1=0x00.
- Bank control outputs are decoded from registered state only; there is no combinational path from cmd_* inputs to bank_* outputs.
- Latency in cycles from the accept edge to the done pulse (the FIN cycle):
  - LDI: 2
  - MOV: 3
  - READ: 2
  - SWAP: 5
- A bank write takes effect at the rising edge that ends WR_A or WR_B.
- FIN returns to IDLE. The next command can therefore be accepted no earlier than 1 cycle after done. Sustained issue rate is one LDI per 3 cycles.
- RESET mid-command aborts it at once:
  - No further bank write is issued and done is not pulsed.
  - A write whose edge has already occurred stands; the bank is reset by the same RESET in any case.

## Test plan
- Reset, then LDI rd=3 imm=0x5A → bank_en_in=3 and bank_wdata=0x5A exactly one cycle after accept; done 2 cycles after accept; register 3 = 0x5A.
- After the above, MOV rd=5 rs=3 → bank_out_index=3 with bank_out_enable=1 for one cycle, then bank_en_in=5 with bank_wdata=0x5A; register 5 = 0x5A; done 3 cycles after accept.
- Registers 2=0x11 and 6=0xEE, SWAP rd=2 rs=6 → reads of 6 then 2, writes 2←0xEE then 6←0x11; done 5 cycles after accept; bank_out_enable and bank_en_in are never nonzero in the same cycle.
- LDI rd=0 imm=0xFF, then READ rs=0 → bank_en_in stays 0 throughout; rsp_valid pulses with rsp_data=0x00.
- Hold cmd_valid high with a second LDI during a MOV → cmd_ready=0 until IDLE; second command accepted 1 cycle after the first done; no command lost or duplicated.
- Assert RESET during RD_B of a SWAP → all outputs return to reset values immediately; no write to rd or rs; done never pulses; cmd_ready=1 after RESET releases.
